// File: rtl/csr_pkg.sv
// Shared CSR definitions for csr_file: machine-mode CSR addresses,
// the RV32I misa constant and mstatus interrupt-enable bit positions.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS   = 12'h300;
    localparam logic [11:0] CSR_MISA      = 12'h301;
    localparam logic [11:0] CSR_MTVEC     = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
    localparam logic [11:0] CSR_MEPC      = 12'h341;
    localparam logic [11:0] CSR_MCAUSE    = 12'h342;
    localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
    localparam logic [11:0] CSR_CYCLE     = 12'hC00;
    localparam logic [11:0] CSR_INSTRET   = 12'hC02;
    localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
    localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
    localparam logic [11:0] CSR_MHARTID   = 12'hF14;

    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit performance counter with independently writable halves.
// Ports: clk_i, rst_n_i, inc_i (count enable), wr_lo_i/wr_hi_i (half
// writes, take priority over inc_i), wdata_i (32-bit), value_o (64-bit).
module csr_counter64 (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        inc_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wdata_i,
    output logic [63:0] value_o
);

    logic [63:0] cnt_q;
    logic [63:0] cnt_d;

    // A write to either half freezes counting for that cycle; the
    // unwritten half holds, so no carry can leak across.
    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo_i || wr_hi_i) begin
            if (wr_lo_i) cnt_d[31:0]  = wdata_i;
            if (wr_hi_i) cnt_d[63:32] = wdata_i;
        end else if (inc_i) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= 64'd0;
        else          cnt_q <= cnt_d;
    end

    assign value_o = cnt_q;

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for a single-hart RV32I core.
// Ports: clk_i, rst_n_i, en_i (pipeline enable), csr_rd_addr_i ->
// csr_rd_data_o / csr_rd_illegal_o (combinational), csr_wr_en_i,
// csr_wr_addr_i, csr_wr_data_i, retire_i, csr_wr_illegal_o (1-cycle pulse).
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter logic [31:0] MTVEC_RST = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        en_i,
    input  logic [11:0] csr_rd_addr_i,
    output logic [31:0] csr_rd_data_o,
    output logic        csr_rd_illegal_o,
    input  logic        csr_wr_en_i,
    input  logic [11:0] csr_wr_addr_i,
    input  logic [31:0] csr_wr_data_i,
    input  logic        retire_i,
    output logic        csr_wr_illegal_o
);

    localparam logic [31:0] MTVEC_RST_V = {MTVEC_RST[31:2], 2'b00};

    logic        wr_fire;
    logic        wr_legal;

    logic        mie_q;
    logic        mpie_q;
    logic [31:0] mtvec_q;
    logic [31:0] mscratch_q;
    logic [31:0] mepc_q;
    logic [31:0] mcause_q;
    logic        wr_illegal_q;

    logic [31:0] mstatus_val;
    logic [63:0] cycle_val;
    logic [63:0] instret_val;

    assign wr_fire = csr_wr_en_i & en_i;

    // Only these addresses accept writes; anything else, including
    // the read-only 0xCxx/0xFxx space and misa, flags an illegal write.
    always_comb begin
        wr_legal = 1'b0;
        case (csr_wr_addr_i)
            CSR_MSTATUS, CSR_MTVEC, CSR_MSCRATCH,
            CSR_MEPC, CSR_MCAUSE, CSR_MCYCLE,
            CSR_MINSTRET, CSR_MCYCLEH, CSR_MINSTRETH:
                wr_legal = 1'b1;
            default:
                wr_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mie_q        <= 1'b0;
            mpie_q       <= 1'b0;
            mtvec_q      <= MTVEC_RST_V;
            mscratch_q   <= 32'h0;
            mepc_q       <= 32'h0;
            mcause_q     <= 32'h0;
            wr_illegal_q <= 1'b0;
        end else begin
            wr_illegal_q <= wr_fire & ~wr_legal;
            if (wr_fire) begin
                case (csr_wr_addr_i)
                    CSR_MSTATUS: begin
                        mie_q  <= csr_wr_data_i[MSTATUS_MIE];
                        mpie_q <= csr_wr_data_i[MSTATUS_MPIE];
                    end
                    CSR_MTVEC:    mtvec_q    <= {csr_wr_data_i[31:2], 2'b00};
                    CSR_MSCRATCH: mscratch_q <= csr_wr_data_i;
                    CSR_MEPC:     mepc_q     <= {csr_wr_data_i[31:1], 1'b0};
                    CSR_MCAUSE:   mcause_q   <= csr_wr_data_i;
                    default: ;
                endcase
            end
        end
    end

    csr_counter64 u_cycle (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (1'b1),
        .wr_lo_i (wr_fire && csr_wr_addr_i == CSR_MCYCLE),
        .wr_hi_i (wr_fire && csr_wr_addr_i == CSR_MCYCLEH),
        .wdata_i (csr_wr_data_i),
        .value_o (cycle_val)
    );

    csr_counter64 u_instret (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (retire_i & en_i),
        .wr_lo_i (wr_fire && csr_wr_addr_i == CSR_MINSTRET),
        .wr_hi_i (wr_fire && csr_wr_addr_i == CSR_MINSTRETH),
        .wdata_i (csr_wr_data_i),
        .value_o (instret_val)
    );

    always_comb begin
        mstatus_val               = 32'h0;
        mstatus_val[MSTATUS_MIE]  = mie_q;
        mstatus_val[MSTATUS_MPIE] = mpie_q;
    end

    always_comb begin
        csr_rd_data_o    = 32'h0;
        csr_rd_illegal_o = 1'b0;
        case (csr_rd_addr_i)
            CSR_MSTATUS:  csr_rd_data_o = mstatus_val;
            CSR_MISA:     csr_rd_data_o = MISA_VAL;
            CSR_MTVEC:    csr_rd_data_o = mtvec_q;
            CSR_MSCRATCH: csr_rd_data_o = mscratch_q;
            CSR_MEPC:     csr_rd_data_o = mepc_q;
            CSR_MCAUSE:   csr_rd_data_o = mcause_q;
            CSR_MCYCLE,
            CSR_CYCLE:    csr_rd_data_o = cycle_val[31:0];
            CSR_MCYCLEH,
            CSR_CYCLEH:   csr_rd_data_o = cycle_val[63:32];
            CSR_MINSTRET,
            CSR_INSTRET:  csr_rd_data_o = instret_val[31:0];
            CSR_MINSTRETH,
            CSR_INSTRETH: csr_rd_data_o = instret_val[63:32];
            CSR_MHARTID:  csr_rd_data_o = HART_ID;
            default:      csr_rd_illegal_o = 1'b1;
        endcase
    end

    assign csr_wr_illegal_o = wr_illegal_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file.
// Drives writes/reads/retires and compares against hand-computed values.
module tb_csr_file;

    localparam logic [31:0] HART   = 32'h0000_0005;
    localparam logic [31:0] TVEC_R = 32'h0000_1003;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic [11:0] rd_addr;
    logic [31:0] rd_data;
    logic        rd_ill;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;
    logic        retire;
    logic        wr_ill;

    int checks = 0;
    int errors = 0;

    csr_file #(.HART_ID(HART), .MTVEC_RST(TVEC_R)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .en_i             (en),
        .csr_rd_addr_i    (rd_addr),
        .csr_rd_data_o    (rd_data),
        .csr_rd_illegal_o (rd_ill),
        .csr_wr_en_i      (wr_en),
        .csr_wr_addr_i    (wr_addr),
        .csr_wr_data_i    (wr_data),
        .retire_i         (retire),
        .csr_wr_illegal_o (wr_ill)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] a,
                      input logic [31:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        en      = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        rd_addr = 12'h0;
        wr_en   = 1'b0;
        wr_addr = 12'h0;
        wr_data = 32'h0;
        retire  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        rd("rst_mtvec", 12'h305, 32'h0000_1000);
        rd("rst_mstatus", 12'h300, 32'h0);
        rd("rst_mcycle", 12'hB00, 32'h0);
        chk("rst_wr_ill", {31'h0, wr_ill}, 32'h0);

        // Release between edges, then 10 counted edges with en=0.
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rd("mcycle10", 12'hB00, 32'd10);
        rd("cycle10", 12'hC00, 32'd10);
        rd("minstret0", 12'hB02, 32'd0);
        rd("mtvec_rst", 12'h305, 32'h0000_1000);
        rd("misa", 12'h301, 32'h4000_0100);
        rd("mhartid", 12'hF14, HART);
        chk("rd_legal", {31'h0, rd_ill}, 32'h0);
        rd("rd_unimpl", 12'h7C0, 32'h0);
        chk("rd_ill", {31'h0, rd_ill}, 32'h1);

        // WARL masking.
        wr(12'h300, 32'hFFFF_FFFF);
        wr(12'h305, 32'hFFFF_FFFF);
        wr(12'h341, 32'hFFFF_FFFF);
        wr(12'h342, 32'hDEAD_BEEF);
        wr(12'h340, 32'hDEAD_BEEF);
        rd("mstatus_warl", 12'h300, 32'h0000_0088);
        rd("mtvec_warl", 12'h305, 32'hFFFF_FFFC);
        rd("mepc_warl", 12'h341, 32'hFFFF_FFFE);
        rd("mcause", 12'h342, 32'hDEAD_BEEF);
        chk("legal_no_ill", {31'h0, wr_ill}, 32'h0);

        // Read-only / unimplemented writes.
        wr(12'hF14, 32'h1234);
        chk("ro_ill_1", {31'h0, wr_ill}, 32'h1);
        tick();
        chk("ro_ill_0", {31'h0, wr_ill}, 32'h0);
        rd("mhartid_kept", 12'hF14, HART);
        wr(12'h301, 32'h0);
        chk("misa_ill", {31'h0, wr_ill}, 32'h1);
        wr(12'h7C0, 32'h0);
        chk("unimpl_ill", {31'h0, wr_ill}, 32'h1);
        wr(12'hC00, 32'h0);
        chk("shadow_ill", {31'h0, wr_ill}, 32'h1);
        tick();

        // Read-during-write, then gated write.
        rd_addr = 12'h340;
        wr_en   = 1'b1;
        en      = 1'b1;
        wr_addr = 12'h340;
        wr_data = 32'h0000_00A5;
        #1;
        chk("rdw_old", rd_data, 32'hDEAD_BEEF);
        tick();
        wr_en = 1'b0;
        chk("rdw_new", rd_data, 32'h0000_00A5);
        en      = 1'b0;
        wr_en   = 1'b1;
        wr_data = 32'h0000_005A;
        tick();
        chk("gated_keep", rd_data, 32'h0000_00A5);
        wr_addr = 12'hF14;
        tick();
        chk("gated_no_ill", {31'h0, wr_ill}, 32'h0);
        wr_en = 1'b0;

        // Low-to-high carry on the cycle counter.
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0);
        rd("cyc_lo_pre", 12'hB00, 32'hFFFF_FFFF);
        rd("cyc_hi_pre", 12'hB80, 32'h0);
        tick();
        tick();
        rd("cyc_hi_carry", 12'hB80, 32'h1);
        rd("cyc_lo_carry", 12'hB00, 32'h1);
        rd("cycleh_sh", 12'hC80, 32'h1);

        // Write beats a simultaneous retire.
        retire = 1'b1;
        wr(12'hB02, 32'd5);
        rd("instret_wr", 12'hB02, 32'd5);
        tick();
        rd("instret_inc", 12'hB02, 32'd6);
        en = 1'b0;
        tick();
        rd("instret_gate", 12'hC02, 32'd6);
        retire = 1'b0;

        // 64-bit wrap.
        wr(12'hB82, 32'hFFFF_FFFF);
        wr(12'hB02, 32'hFFFF_FFFF);
        retire = 1'b1;
        tick();
        retire = 1'b0;
        en     = 1'b0;
        rd("wrap_lo", 12'hB02, 32'h0);
        rd("wrap_hi", 12'hB82, 32'h0);

        // Reset asserted mid-write discards the write.
        rd_addr = 12'h340;
        wr_en   = 1'b1;
        en      = 1'b1;
        wr_addr = 12'h340;
        wr_data = 32'h77;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_mscratch", rd_data, 32'h0);
        tick();
        wr_en = 1'b0;
        en    = 1'b0;
        chk("rst_mscratch", rd_data, 32'h0);
        rd("rst_mtvec2", 12'h305, 32'h0000_1000);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        rd("resume_cyc", 12'hB00, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter HART_ID, default 32'h0, value returned by mhartid.
REQ-002 SHALL have parameter MTVEC_RST, default 32'h0, mtvec reset value (bits[1:0] forced 0).
REQ-003 SHALL have port clk_i  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n_i  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en_i  in  1  pipeline enable; gates writes and instret counting.
REQ-006 SHALL have port csr_rd_addr_i  in  12  read address from decode/execute.
REQ-007 SHALL have port csr_rd_data_o  out  32  combinational read data.
REQ-008 SHALL have port csr_rd_illegal_o  out  1  combinational; read address unimplemented.
REQ-009 SHALL have port csr_wr_en_i  in  1  write strobe from execute.
REQ-010 SHALL have port csr_wr_addr_i  in  12  write address.
REQ-011 SHALL have port csr_wr_data_i  in  32  write data, final value (set/clear already applied upstream).
REQ-012 SHALL have port retire_i  in  1  one instruction retired this cycle.
REQ-013 SHALL have port csr_wr_illegal_o  out  1  registered one-cycle pulse; last write was to a read-only or unimplemented address.

Function
REQ-014 SHALL implement: mstatus 0x300, misa 0x301 (RO), mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mcycleh 0xB80, minstreth 0xB82, cycle/instret/cycleh/instreth 0xC00/0xC02/0xC80/0xC82 (RO shadows), mhartid 0xF14 (RO).
REQ-015 SHALL implement mstatus with only MIE (bit 3) and MPIE (bit 7) writable; all other bits read 0.
REQ-016 SHALL read misa as constant 32'h4000_0100 (RV32I).
REQ-017 SHALL force mtvec bits[1:0] and mepc bit[0] to 0 on write (WARL).
REQ-018 SHALL store mscratch and mcause as full 32-bit values.
REQ-019 SHALL return 32'h0 and assert csr_rd_illegal_o for an unimplemented read address.
REQ-020 SHALL perform a write at the rising edge where csr_wr_en_i & en_i are both 1; with en_i=0, no write and no illegal pulse.
REQ-021 SHALL ignore writes to RO addresses (address bits[11:10]==2'b11, and misa) or unimplemented addresses, and assert csr_wr_illegal_o for exactly the following cycle.
REQ-022 SHALL return the pre-write value when reading and writing the same address in one cycle; the new value is visible the next cycle.
REQ-023 SHALL increment the 64-bit cycle counter by 1 on every clock edge out of reset, independent of en_i.
REQ-024 SHALL increment the 64-bit instret counter by 1 on each edge where retire_i & en_i are both 1.
REQ-025 SHALL carry from the low into the high half when the low half is 32'hFFFF_FFFF, and wrap 64'hFFFF_FFFF_FFFF_FFFF to 0.
REQ-026 SHALL give a counter-half write priority over the increment in that cycle: the written half takes the write data, the other half holds, and no increment and no carry occur.

Reset
REQ-027 SHALL, while rst_n_i=0, asynchronously clear mstatus, mscratch, mepc, mcause, both counters and csr_wr_illegal_o to 0, and set mtvec to MTVEC_RST with bits[1:0]=0.
REQ-028 SHALL resume counting on the first rising edge after rst_n_i deasserts; reset mid-write discards the write.

Structure
REQ-029 SHALL take all CSR address constants, the misa value and the mstatus bit positions from a shared package csr_pkg.
REQ-030 SHALL instantiate sub-module csr_counter64 twice (cycle, instret), each with inc, wr_lo, wr_hi, wdata and a 64-bit value.

Verification
REQ-031 SHALL cover reset: release rst_n_i, hold 10 cycles, en_i=0 -> mcycle reads 10, minstret reads 0, mtvec reads MTVEC_RST.
REQ-032 SHALL cover carry: write mcycle=32'hFFFF_FFFF, mcycleh=0 -> two cycles later mcycleh=1 and mcycle=1.
REQ-033 SHALL cover write-vs-increment: write minstret=5 with retire_i=1 in the same cycle -> reads 5 next cycle, then 6 after one more retire.
REQ-034 SHALL cover RO write: write 0x1234 to mhartid -> csr_wr_illegal_o=1 for exactly one cycle; mhartid still reads HART_ID.
REQ-035 SHALL cover WARL: write 32'hFFFF_FFFF to mstatus, mtvec, mepc -> reads 32'h0000_0088, 32'hFFFF_FFFC, 32'hFFFF_FFFE.
REQ-036 SHALL cover read-during-write and gating: write mscratch=0xA5 while reading mscratch -> old value that cycle, 0xA5 next; repeat with en_i=0 -> value unchanged.
